divu_seq: RTL and testbench
===========================

# divu_seq

Sequential 32-bit unsigned divider for the MIPS-CPU datapath, directly downstream of the ALU control stage. It consumes the 6-bit function code routed to the divider and starts a DIVU when that code becomes 6'b011011. It iterates one quotient bit per clock for 32 clocks, then presents quotient (LO) and remainder (HI) with a one-cycle write-enable pulse to the HiLo register.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- DIVU_FN, 6'b011011, function code that requests a divide.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fn  input  6  function code from ALU control; level signal, may stay DIVU for many cycles.
- dividend  input  WIDTH  rs operand; sampled only on the start cycle.
- divisor  input  WIDTH  rt operand; sampled only on the start cycle.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; results valid.
- hilo_we  output  1  HiLo write enable; identical timing to done.
- quotient  output  WIDTH  to LO; held until the next start.
- remainder  output  WIDTH  to HI; held until the next start.
- div_zero  output  1  divisor was 0 for the last completed divide; held until the next start.

## Operation
- States: IDLE, RUN, DONE. Reset value of every output and register is 0, with state IDLE.
- A register fn_was_div holds the previous cycle's (fn == DIVU_FN).
- Start condition: state IDLE, fn == DIVU_FN, and fn_was_div == 0. This is a rising edge of the DIVU request.
- A DIVU held high for any number of cycles produces exactly one divide.
- On start:
  - Latch D = divisor, Q = dividend, R = 0, and cnt = 0.
  - Latch dz = (divisor == 0), and clear quotient, remainder and div_zero.
  - Go to RUN.
- RUN iteration (restoring), once per clock:
  - t = {R, Q[WIDTH-1]} - {1'b0, D}, computed in WIDTH+1 bits.
  - If t[WIDTH] == 0: R = t[WIDTH-1:0] and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = {R[WIDTH-2:0], Q[WIDTH-1]} and Q = {Q[WIDTH-2:0], 0}.
  - cnt increments; after the WIDTH-th iteration, go to DONE.
- DONE:
  - quotient = Q, remainder = R, div_zero = dz.
  - done and hilo_we are high for this one cycle; the next edge goes to IDLE.
- Divide by zero needs no special path. The algorithm gives quotient = all ones and remainder = dividend, and div_zero is set.
- Changes on fn, dividend or divisor during RUN/DONE are ignored, and the divide completes. A DIVU rising edge that arrives while busy is dropped; the request must be deasserted and reasserted.
- If rst_n is asserted mid-operation, all state and outputs clear immediately, no done is issued, and the partial result is discarded.

## Timing
- Start sampled at edge k: busy = 1 from k.
- Iterations occur on edges k+1 through k+WIDTH.
- Edge k+WIDTH enters DONE: done = hilo_we = 1 and results are valid for cycle k+WIDTH.
- Edge k+WIDTH+1 returns to IDLE with done = 0 and busy = 0.
- Total latency from start to done is WIDTH clocks (32); the earliest next start is edge k+WIDTH+1.
- busy is low in the DONE cycle.
- quotient/remainder change only at start (cleared) and on DONE entry.

## Test plan
- Reset, then fn = DIVU with 100/7 -> busy for 32 cycles; at start+32, done = hilo_we = 1, quotient = 14, remainder = 2, div_zero = 0.
- 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0; 5 / 9 -> quotient = 0, remainder = 5.
- 0x12345678 / 0 -> quotient = 0xFFFFFFFF, remainder = 0x12345678, div_zero = 1 at start+32.
- fn held at DIVU for 80 cycles -> exactly one done pulse; drop fn for 1 cycle and reassert -> a second divide starts.
- Change dividend/divisor at iteration 10, and pulse fn low then high while busy -> the result matches the original operands and no second divide occurs.
- rst_n low at iteration 16 -> all outputs 0 asynchronously and no done pulse; after release, a new 1000/10 -> quotient = 100, remainder = 0.

Source files
------------

// File: rtl/divu_seq.sv
// rtl/divu_seq.sv - sequential 32-bit unsigned restoring divider (DIVU) feeding HI/LO
// Starts on a rising edge of fn == DIVU_FN, retires one quotient bit per clock.
module divu_seq #(
   parameter int         WIDTH   = 32,
   parameter logic [5:0] DIVU_FN = 6'b011011
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       fn,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic             fn_was_div;
   logic             fn_is_div;
   logic             start;
   logic             last_iter;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] d_reg, q_reg, r_reg;
   logic             dz;
   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] q_nx, r_nx;

   assign fn_is_div = (fn == DIVU_FN);
   assign start     = (state == IDLE) && fn_is_div && !fn_was_div;
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Trial subtraction; the borrow bit decides whether the shifted remainder is restored.
   assign t    = {r_reg, q_reg[WIDTH-1]} - {1'b0, d_reg};
   assign r_nx = t[WIDTH] ? {r_reg[WIDTH-2:0], q_reg[WIDTH-1]} : t[WIDTH-1:0];
   assign q_nx = {q_reg[WIDTH-2:0], ~t[WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == RUN);
      done    = (state == DONE);
      hilo_we = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fn_was_div <= 1'b0;
         cnt        <= '0;
         d_reg      <= '0;
         q_reg      <= '0;
         r_reg      <= '0;
         dz         <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
         div_zero   <= 1'b0;
      end else begin
         fn_was_div <= fn_is_div;
         if (start) begin
            d_reg     <= divisor;
            q_reg     <= dividend;
            r_reg     <= '0;
            cnt       <= '0;
            dz        <= (divisor == '0);
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
         end else if (state == RUN) begin
            q_reg <= q_nx;
            r_reg <= r_nx;
            cnt   <= cnt + 1'b1;
            // Results are published on the edge that enters DONE.
            if (last_iter) begin
               quotient  <= q_nx;
               remainder <= r_nx;
               div_zero  <= dz;
            end
         end
      end
   end

endmodule

// File: tb/tb_divu_seq.sv
// tb/tb_divu_seq.sv - scoreboard bench for divu_seq against a plain-arithmetic model
// Stimulus pushes expected {quotient, remainder, div_zero}; a monitor pops on each done.
module tb_divu_seq;

   localparam int         W    = 32;
   localparam logic [5:0] DIVU = 6'b011011;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [5:0]   fn = 6'h00;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, hilo_we, div_zero;
   logic [W-1:0] quotient, remainder;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;

   divu_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fn        (fn),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .hilo_we   (hilo_we),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hilo_we !== done) chk("hilo_we_eq_done", {31'd0, hilo_we}, {31'd0, done});
         if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      fn       = DIVU;
      exp_q.push_back(model(a, b));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) break;
         lat++;
         @(negedge clk);
      end
   endtask

   // Full divide with latency/handshake checks; fn returns low after the start edge.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      issue(a, b);
      @(negedge clk);
      fn = 6'h00;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_done(lat);
      chk("latency", lat, 32'd32);
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("busy_low_in_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int base;
      int lat;
      logic [W-1:0] a, b;

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div(32'd100, 32'd7);
      run_div(32'hFFFF_FFFF, 32'd1);
      run_div(32'd5, 32'd9);
      run_div(32'h1234_5678, 32'd0);

      // Held request: one divide only; a drop and reassert starts another.
      base = done_cnt;
      issue(32'd77, 32'd5);
      repeat (80) @(negedge clk);
      chk("held_one_done", done_cnt - base, 32'd1);
      fn = 6'h00;
      @(negedge clk);
      fn = DIVU;
      exp_q.push_back(model(32'd77, 32'd5));
      @(negedge clk);
      wait_done(lat);
      chk("reassert_latency", lat, 32'd32);
      fn = 6'h00;
      repeat (2) @(negedge clk);
      chk("reassert_two_done", done_cnt - base, 32'd2);

      // Operand changes and a fn re-pulse while busy are ignored.
      base = done_cnt;
      issue(32'hCAFE_F00D, 32'd1234);
      @(negedge clk);
      fn = 6'h00;
      repeat (10) @(negedge clk);
      dividend = 32'd1;
      divisor  = 32'd1;
      fn       = DIVU;
      @(negedge clk);
      fn = 6'h00;
      repeat (60) @(negedge clk);
      chk("busy_pulse_one_done", done_cnt - base, 32'd1);

      // Asynchronous reset mid-divide discards the operation.
      base = done_cnt;
      issue(32'hDEAD_BEEF, 32'd3);
      @(negedge clk);
      fn = 6'h00;
      repeat (16) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_hilo_we", {31'd0, hilo_we}, 32'd0);
      chk("arst_quotient", quotient, 32'd0);
      chk("arst_remainder", remainder, 32'd0);
      chk("arst_div_zero", {31'd0, div_zero}, 32'd0);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", done_cnt - base, 32'd0);
      run_div(32'd1000, 32'd10);

      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         run_div(a, b);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
